// File: rtl/buscaminas_pkg.sv
// Shared types and constants for the 8x8 minesweeper controller.
package buscaminas_pkg;

  localparam int unsigned N            = 8;
  localparam int unsigned CELDAS       = 64;
  localparam int unsigned MAX_BOMBAS   = 63;

  localparam int unsigned BIT_BOMBA    = 6;
  localparam int unsigned BIT_REVELADA = 5;
  localparam int unsigned BIT_BANDERA  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GENERAR = 3'd1,
    JUGAR   = 3'd2,
    REVELAR = 3'd3,
    BANDERA = 3'd4,
    GANO    = 3'd5,
    PERDIO  = 3'd6
  } estado_t;

  // Clamp the requested bomb count into 1..max_b.
  function automatic logic [7:0] clamp_bombas(input logic [7:0] sel, input int unsigned max_b);
    if (sel == 8'd0) return 8'd1;
    if (32'(sel) > max_b) return 8'(max_b);
    return sel;
  endfunction

endpackage

// File: rtl/buscaminas_control_cursor.sv
// Wrapping row/column cursor for an N x N board.
module cursor_8x8
  import buscaminas_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_arriba,
  input  logic                 i_abajo,
  input  logic                 i_izq,
  input  logic                 i_der,
  output logic [$clog2(N)-1:0] o_i,
  output logic [$clog2(N)-1:0] o_j
);

  localparam int unsigned W = $clog2(N);
  localparam logic [W-1:0] ULT = W'(N - 1);

  logic [W-1:0] r_i;
  logic [W-1:0] r_j;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_arriba) begin
      r_i <= (r_i == '0) ? ULT : r_i - W'(1);
    end else if (i_abajo) begin
      r_i <= (r_i == ULT) ? '0 : r_i + W'(1);
    end else if (i_izq) begin
      r_j <= (r_j == '0) ? ULT : r_j - W'(1);
    end else if (i_der) begin
      r_j <= (r_j == ULT) ? '0 : r_j + W'(1);
    end
  end

  assign o_i = r_i;
  assign o_j = r_j;

endmodule

// File: rtl/buscaminas_control.sv
// Minesweeper game controller: sequences board generation, cursor, reveal and flag strobes.
module buscaminas_control
  import buscaminas_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned MAX_BOMBAS = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       btn_revelar,
  input  logic       btn_bandera,
  input  logic [7:0] bombas_sel,
  input  logic       tablero_generado,
  input  logic [6:0] celda_actual,
  output logic [7:0] cant_bombas,
  output logic [2:0] i_actual,
  output logic [2:0] j_actual,
  output logic       enable_matriz,
  output logic       enable_casillas,
  output logic       enable_bandera,
  output logic [6:0] banderas_rest,
  output logic       victoria,
  output logic       derrota,
  output logic [2:0] estado
);

  estado_t    r_estado, w_estado_sig;
  logic [7:0] r_cant, w_cant_sig;
  logic [6:0] r_band, w_band_sig;
  logic [6:0] r_rev, w_rev_sig;
  logic       r_bomba, w_bomba_sig;
  logic       r_en_matriz, r_en_casillas, r_en_bandera, r_victoria, r_derrota;

  logic       w_clr, w_arriba, w_abajo, w_izq, w_der;
  logic [7:0] w_clamp;
  logic [6:0] w_meta;
  logic       w_bandera_cel, w_revelada_cel;
  logic       w_unused;

  assign w_clamp        = clamp_bombas(bombas_sel, MAX_BOMBAS);
  assign w_meta         = 7'(N * N) - r_cant[6:0];
  assign w_bandera_cel  = celda_actual[BIT_BANDERA];
  assign w_revelada_cel = celda_actual[BIT_REVELADA];
  assign w_unused       = ^celda_actual[3:0];

  // Next-state and datapath update
  always_comb begin
    w_estado_sig = r_estado;
    w_cant_sig   = r_cant;
    w_band_sig   = r_band;
    w_rev_sig    = r_rev;
    w_bomba_sig  = r_bomba;
    w_clr        = 1'b0;
    w_arriba     = 1'b0;
    w_abajo      = 1'b0;
    w_izq        = 1'b0;
    w_der        = 1'b0;

    case (r_estado)
      IDLE, GANO, PERDIO: begin
        if (start) begin
          w_cant_sig   = w_clamp;
          w_band_sig   = w_clamp[6:0];
          w_rev_sig    = '0;
          w_clr        = 1'b1;
          w_estado_sig = GENERAR;
        end
      end
      GENERAR: begin
        if (tablero_generado) w_estado_sig = JUGAR;
      end
      JUGAR: begin
        // Only the highest-priority pressed button acts, even if it is then ignored.
        if (btn_revelar) begin
          if (!w_bandera_cel && !w_revelada_cel) begin
            w_bomba_sig  = celda_actual[BIT_BOMBA];
            w_estado_sig = REVELAR;
          end
        end else if (btn_bandera) begin
          if (!w_revelada_cel) begin
            if (w_bandera_cel) begin
              w_band_sig   = r_band + 7'd1;
              w_estado_sig = BANDERA;
            end else if (r_band != '0) begin
              w_band_sig   = r_band - 7'd1;
              w_estado_sig = BANDERA;
            end
          end
        end else if (btn_arriba) begin
          w_arriba = 1'b1;
        end else if (btn_abajo) begin
          w_abajo = 1'b1;
        end else if (btn_izq) begin
          w_izq = 1'b1;
        end else if (btn_der) begin
          w_der = 1'b1;
        end
      end
      REVELAR: begin
        if (r_bomba) begin
          w_estado_sig = PERDIO;
        end else begin
          w_rev_sig    = r_rev + 7'd1;
          w_estado_sig = (w_rev_sig == w_meta) ? GANO : JUGAR;
        end
      end
      BANDERA: begin
        w_estado_sig = JUGAR;
      end
      default: begin
        w_estado_sig = IDLE;
      end
    endcase
  end

  // State, datapath and Moore outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado      <= IDLE;
      r_cant        <= '0;
      r_band        <= '0;
      r_rev         <= '0;
      r_bomba       <= 1'b0;
      r_en_matriz   <= 1'b0;
      r_en_casillas <= 1'b0;
      r_en_bandera  <= 1'b0;
      r_victoria    <= 1'b0;
      r_derrota     <= 1'b0;
    end else begin
      r_estado      <= w_estado_sig;
      r_cant        <= w_cant_sig;
      r_band        <= w_band_sig;
      r_rev         <= w_rev_sig;
      r_bomba       <= w_bomba_sig;
      r_en_matriz   <= (w_estado_sig == GENERAR);
      r_en_casillas <= (w_estado_sig == REVELAR);
      r_en_bandera  <= (w_estado_sig == BANDERA);
      r_victoria    <= (w_estado_sig == GANO);
      r_derrota     <= (w_estado_sig == PERDIO);
    end
  end

  cursor_8x8 #(.N(N)) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_arriba (w_arriba),
    .i_abajo  (w_abajo),
    .i_izq    (w_izq),
    .i_der    (w_der),
    .o_i      (i_actual),
    .o_j      (j_actual)
  );

  assign cant_bombas     = r_cant;
  assign banderas_rest   = r_band;
  assign enable_matriz   = r_en_matriz;
  assign enable_casillas = r_en_casillas;
  assign enable_bandera  = r_en_bandera;
  assign victoria        = r_victoria;
  assign derrota         = r_derrota;
  assign estado          = r_estado;

endmodule

// File: tb/tb_buscaminas_control.sv
// Directed self-checking bench for buscaminas_control.
module tb_buscaminas_control;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       btn_arriba, btn_abajo, btn_izq, btn_der, btn_revelar, btn_bandera;
  logic [7:0] bombas_sel;
  logic       tablero_generado;
  logic [6:0] celda_actual;
  logic [7:0] cant_bombas;
  logic [2:0] i_actual, j_actual;
  logic       enable_matriz, enable_casillas, enable_bandera;
  logic [6:0] banderas_rest;
  logic       victoria, derrota;
  logic [2:0] estado;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_GEN = 3'd1, S_JUG = 3'd2, S_REV = 3'd3,
                         S_BAN = 3'd4, S_GANO = 3'd5, S_PERD = 3'd6;

  always #5 clk = ~clk;

  buscaminas_control dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .btn_arriba       (btn_arriba),
    .btn_abajo        (btn_abajo),
    .btn_izq          (btn_izq),
    .btn_der          (btn_der),
    .btn_revelar      (btn_revelar),
    .btn_bandera      (btn_bandera),
    .bombas_sel       (bombas_sel),
    .tablero_generado (tablero_generado),
    .celda_actual     (celda_actual),
    .cant_bombas      (cant_bombas),
    .i_actual         (i_actual),
    .j_actual         (j_actual),
    .enable_matriz    (enable_matriz),
    .enable_casillas  (enable_casillas),
    .enable_bandera   (enable_bandera),
    .banderas_rest    (banderas_rest),
    .victoria         (victoria),
    .derrota          (derrota),
    .estado           (estado)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_estado"}, 8'(estado), 8'(S_IDLE));
    chk({tag, "_i"}, 8'(i_actual), 8'd0);
    chk({tag, "_j"}, 8'(j_actual), 8'd0);
    chk({tag, "_cant"}, cant_bombas, 8'd0);
    chk({tag, "_band"}, 8'(banderas_rest), 8'd0);
    chk({tag, "_en"}, 8'({enable_matriz, enable_casillas, enable_bandera}), 8'd0);
    chk({tag, "_res"}, 8'({victoria, derrota}), 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    btn_arriba = 1'b0; btn_abajo = 1'b0; btn_izq = 1'b0; btn_der = 1'b0;
    btn_revelar = 1'b0; btn_bandera = 1'b0;
    bombas_sel = 8'd0; tablero_generado = 1'b0; celda_actual = 7'd0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    // Game 1: 10 bombs
    bombas_sel = 8'd10; start = 1'b1; tick(); start = 1'b0;
    chk("g1_estado_gen", 8'(estado), 8'(S_GEN));
    chk("g1_en_matriz", 8'(enable_matriz), 8'd1);
    chk("g1_cant", cant_bombas, 8'd10);
    chk("g1_band", 8'(banderas_rest), 8'd10);
    bombas_sel = 8'd20; start = 1'b1; tick(); start = 1'b0;
    chk("g1_start_ignored_cant", cant_bombas, 8'd10);
    chk("g1_still_gen_matriz", 8'(enable_matriz), 8'd1);
    tablero_generado = 1'b1; tick(); tablero_generado = 1'b0;
    chk("g1_jugar", 8'(estado), 8'(S_JUG));
    chk("g1_matriz_off", 8'(enable_matriz), 8'd0);

    btn_arriba = 1'b1; tick(); btn_arriba = 1'b0;
    chk("mv_arriba_wrap", 8'({i_actual, j_actual}), 8'({3'd7, 3'd0}));
    btn_izq = 1'b1; tick(); btn_izq = 1'b0;
    chk("mv_izq_wrap", 8'({i_actual, j_actual}), 8'({3'd7, 3'd7}));
    btn_arriba = 1'b1; btn_der = 1'b1; tick(); btn_arriba = 1'b0; btn_der = 1'b0;
    chk("mv_arriba_over_der", 8'({i_actual, j_actual}), 8'({3'd6, 3'd7}));
    btn_der = 1'b1; tick(); btn_der = 1'b0;
    chk("mv_der_wrap", 8'({i_actual, j_actual}), 8'({3'd6, 3'd0}));
    btn_abajo = 1'b1; tick(); btn_abajo = 1'b0;
    chk("mv_abajo", 8'({i_actual, j_actual}), 8'({3'd7, 3'd0}));

    celda_actual = 7'b0000011; btn_revelar = 1'b1; tick(); btn_revelar = 1'b0;
    chk("rev_estado", 8'(estado), 8'(S_REV));
    chk("rev_strobe", 8'({enable_casillas, enable_bandera}), 8'b10);
    tick();
    chk("rev_back_jugar", 8'(estado), 8'(S_JUG));
    chk("rev_strobe_off", 8'(enable_casillas), 8'd0);

    celda_actual = 7'b0100011; btn_revelar = 1'b1; tick(); btn_revelar = 1'b0;
    chk("rev_revealed_ignored", 8'({estado, enable_casillas}), 8'({S_JUG, 1'b0}));

    celda_actual = 7'b0000000; btn_bandera = 1'b1; tick(); btn_bandera = 1'b0;
    chk("flag_estado", 8'(estado), 8'(S_BAN));
    chk("flag_strobe", 8'({enable_casillas, enable_bandera}), 8'b01);
    chk("flag_band", 8'(banderas_rest), 8'd9);
    tick();
    chk("flag_back_jugar", 8'({estado, enable_bandera}), 8'({S_JUG, 1'b0}));

    celda_actual = 7'b0010000; btn_revelar = 1'b1; btn_arriba = 1'b1; tick();
    btn_revelar = 1'b0; btn_arriba = 1'b0;
    chk("rev_flagged_ignored", 8'(estado), 8'(S_JUG));
    chk("rev_wins_over_move", 8'(i_actual), 8'd7);

    celda_actual = 7'b1000011; btn_revelar = 1'b1; tick(); btn_revelar = 1'b0;
    chk("bomb_rev", 8'({estado, enable_casillas}), 8'({S_REV, 1'b1}));
    tick();
    chk("bomb_perdio", 8'(estado), 8'(S_PERD));
    chk("bomb_result", 8'({victoria, derrota}), 8'b01);
    btn_arriba = 1'b1; tick(); btn_arriba = 1'b0;
    chk("perdio_move_ignored", 8'({estado, i_actual}), 8'({S_PERD, 3'd7}));

    // Game 2: bombas_sel = 0 clamps to 1
    bombas_sel = 8'd0; start = 1'b1; tick(); start = 1'b0;
    chk("g2_cant_clamp0", cant_bombas, 8'd1);
    chk("g2_band", 8'(banderas_rest), 8'd1);
    chk("g2_restart", 8'({estado, derrota}), 8'({S_GEN, 1'b0}));
    chk("g2_cursor_clr", 8'({i_actual, j_actual}), 8'd0);
    tablero_generado = 1'b1; tick(); tablero_generado = 1'b0;

    celda_actual = 7'b0000000; btn_bandera = 1'b1; tick(); btn_bandera = 1'b0;
    chk("g2_flag1", 8'({enable_bandera, banderas_rest}), 8'({1'b1, 7'd0}));
    tick();
    btn_der = 1'b1; tick(); btn_der = 1'b0;
    btn_bandera = 1'b1; tick(); btn_bandera = 1'b0;
    chk("g2_flag_none_left", 8'({estado, enable_bandera}), 8'({S_JUG, 1'b0}));
    chk("g2_flag_none_band", 8'(banderas_rest), 8'd0);
    btn_izq = 1'b1; tick(); btn_izq = 1'b0;
    celda_actual = 7'b0010000; btn_bandera = 1'b1; tick(); btn_bandera = 1'b0;
    chk("g2_unflag", 8'({estado, enable_bandera}), 8'({S_BAN, 1'b1}));
    chk("g2_unflag_band", 8'(banderas_rest), 8'd1);
    tick();
    celda_actual = 7'b0100000; btn_bandera = 1'b1; tick(); btn_bandera = 1'b0;
    chk("g2_flag_revealed_ign", 8'({estado, banderas_rest}), 8'({S_JUG, 7'd1}));

    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst_jugar");

    // Game 3: 62 bombs, two safe reveals to win
    bombas_sel = 8'd62; start = 1'b1; tick(); start = 1'b0;
    tablero_generado = 1'b1; tick(); tablero_generado = 1'b0;
    celda_actual = 7'b0000001; btn_revelar = 1'b1; tick(); btn_revelar = 1'b0;
    tick();
    chk("g3_first_rev", 8'({estado, victoria}), 8'({S_JUG, 1'b0}));
    btn_revelar = 1'b1; tick(); btn_revelar = 1'b0;
    tick();
    chk("g3_win", 8'({estado, victoria, derrota}), 8'({S_GANO, 2'b10}));

    // Game 4 from GANO: 200 clamps to 63, single safe cell
    bombas_sel = 8'd200; start = 1'b1; tick(); start = 1'b0;
    chk("g4_cant_clamp200", cant_bombas, 8'd63);
    chk("g4_band", 8'(banderas_rest), 8'd63);
    chk("g4_restart", 8'({estado, victoria}), 8'({S_GEN, 1'b0}));
    tablero_generado = 1'b1; tick(); tablero_generado = 1'b0;
    btn_revelar = 1'b1; tick(); btn_revelar = 1'b0;
    tick();
    chk("g4_win", 8'({estado, victoria}), 8'({S_GANO, 1'b1}));
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst_gano");

    // Reset abandons generation
    bombas_sel = 8'd5; start = 1'b1; tick(); start = 1'b0;
    chk("g5_gen", 8'(enable_matriz), 8'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("rst_generar");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
